// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, parity constants and bit-timing helper for the UART echo bridge
package uart_pkg;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY} tx_state_t;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: mid-bit sampling, parity latched per frame, one stop bit checked
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 9600,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 line,
  input  logic                 parity_mode,
  output logic                 done,
  output logic                 error,
  output logic [DATA_BITS-1:0] data
);
  localparam int CPB  = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB + 1);
  localparam int LAST = DATA_BITS + 2;
  localparam int IW   = $clog2(LAST + 1);

  logic [1:0]         sync;
  logic               active;
  logic               pmode;
  logic [CW-1:0]      cnt;
  logic [IW-1:0]      idx;
  logic [DATA_BITS:0] sh;
  logic               bit_in;
  logic               sample;

  assign bit_in = sync[1];
  // Index 0 is the start bit, sampled at half a bit; later bits are one full bit apart.
  assign sample = active && (cnt == ((idx == '0) ? CW'(HALF - 1) : CW'(CPB - 1)));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync   <= 2'b11;
      active <= 1'b0;
      pmode  <= PARITY_EVEN;
      cnt    <= '0;
      idx    <= '0;
      sh     <= '0;
      done   <= 1'b0;
      error  <= 1'b0;
      data   <= '0;
    end else begin
      sync <= {sync[0], line};
      done <= 1'b0;
      if (!active) begin
        cnt <= '0;
        idx <= '0;
        if (!bit_in) begin
          active <= 1'b1;
          pmode  <= parity_mode;
        end
      end else if (!sample) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
        if (idx == '0) begin
          if (bit_in) active <= 1'b0;
          else        idx    <= idx + 1'b1;
        end else if (idx != IW'(LAST)) begin
          sh  <= {bit_in, sh[DATA_BITS:1]};
          idx <= idx + 1'b1;
        end else begin
          active <= 1'b0;
          done   <= 1'b1;
          data   <= sh[DATA_BITS-1:0];
          error  <= !bit_in || ((^sh) != (pmode == PARITY_ODD));
        end
      end
    end
  end

endmodule

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - synchronous FIFO with show-ahead head output and occupancy level
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  // A full FIFO still accepts a push when the same cycle frees a slot.
  assign do_pop  = pop && (level != '0);
  assign do_push = push && (!full || do_pop);
  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign head    = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: start, data LSB first, parity, STOP_BITS stop bits
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 9600,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 parity_mode,
  output logic                 tx,
  output logic                 busy
);
  localparam int CPB   = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int CW    = $clog2(CPB + 1);
  localparam int FRAME = DATA_BITS + 2 + STOP_BITS;
  localparam int SW    = FRAME - 1;
  localparam int BW    = $clog2(FRAME + 1);

  logic [CW-1:0] cnt;
  logic [BW-1:0] bits;
  logic [SW-1:0] shreg;
  logic          parity_bit;

  assign parity_bit = (parity_mode == PARITY_EVEN) ? ^data : ~^data;

  // The start bit is driven straight from the launch edge; shreg holds the rest of the frame.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx    <= 1'b1;
      busy  <= 1'b0;
      cnt   <= '0;
      bits  <= '0;
      shreg <= '1;
    end else if (!busy) begin
      cnt  <= '0;
      bits <= '0;
      if (start) begin
        shreg <= {{STOP_BITS{1'b1}}, parity_bit, data};
        busy  <= 1'b1;
        tx    <= 1'b0;
      end
    end else if (cnt != CW'(CPB - 1)) begin
      cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
      if (bits == BW'(FRAME - 1)) begin
        busy <= 1'b0;
        tx   <= 1'b1;
      end else begin
        bits  <= bits + 1'b1;
        tx    <= shreg[0];
        shreg <= {1'b1, shreg[SW-1:1]};
      end
    end
  end

endmodule

// File: rtl/uart_echo_bridge.sv
// rtl/uart_echo_bridge.sv - UART rx -> FIFO -> tx echo bridge with sticky status
// Define UART_BRIDGE_STATS_EN to add the saturating err_cnt/ovf_cnt outputs.
module uart_echo_bridge
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        parity_mode,
  input  logic                        uart_rx,
  output logic                        uart_tx,
  input  logic                        clr_status,
  output logic [$clog2(FIFO_DEPTH):0] rx_level,
  output logic                        overflow,
  output logic                        frame_err
`ifdef UART_BRIDGE_STATS_EN
  ,
  output logic [15:0]                 err_cnt,
  output logic [15:0]                 ovf_cnt
`endif
);
  logic                 rx_done;
  logic                 rx_error;
  logic [DATA_BITS-1:0] rx_data;
  logic [DATA_BITS-1:0] fifo_head;
  logic [DATA_BITS-1:0] tx_data;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 tx_start;
  logic                 tx_busy;
  logic                 busy_seen;
  logic                 err_ev;
  logic                 ovf_ev;
  logic                 err_pend;
  logic                 ovf_pend;
  tx_state_t            state;
  tx_state_t            state_next;

  uart_rx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .DATA_BITS (DATA_BITS)
  ) u_rx (
    .clk         (clk),
    .rstn        (rstn),
    .line        (uart_rx),
    .parity_mode (parity_mode),
    .done        (rx_done),
    .error       (rx_error),
    .data        (rx_data)
  );

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (rx_data),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (rx_level)
  );

  uart_tx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .DATA_BITS (DATA_BITS),
    .STOP_BITS (STOP_BITS)
  ) u_tx (
    .clk         (clk),
    .rstn        (rstn),
    .start       (tx_start),
    .data        (tx_data),
    .parity_mode (parity_mode),
    .tx          (uart_tx),
    .busy        (tx_busy)
  );

  assign fifo_push = rx_done && !rx_error;
  assign err_ev    = rx_done && rx_error;
  assign ovf_ev    = fifo_push && fifo_full && !fifo_pop;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      tx_data   <= '0;
      busy_seen <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && state_next == LAUNCH) tx_data <= fifo_head;
      busy_seen <= (state == WAIT_BUSY) && (busy_seen || tx_busy);
    end
  end

  always_comb begin
    state_next = state;
    tx_start   = 1'b0;
    fifo_pop   = 1'b0;
    case (state)
      IDLE:      if (!fifo_empty && !tx_busy) state_next = LAUNCH;
      LAUNCH: begin
        tx_start   = 1'b1;
        fifo_pop   = 1'b1;
        state_next = WAIT_BUSY;
      end
      WAIT_BUSY: if (busy_seen && !tx_busy) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // An event coinciding with clr_status is held in *_pend and lands one cycle later.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_err <= 1'b0;
      overflow  <= 1'b0;
      err_pend  <= 1'b0;
      ovf_pend  <= 1'b0;
    end else begin
      err_pend  <= clr_status && err_ev;
      ovf_pend  <= clr_status && ovf_ev;
      frame_err <= clr_status ? 1'b0 : (frame_err || err_ev || err_pend);
      overflow  <= clr_status ? 1'b0 : (overflow || ovf_ev || ovf_pend);
    end
  end

`ifdef UART_BRIDGE_STATS_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_cnt <= '0;
      ovf_cnt <= '0;
    end else begin
      if (err_ev && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 1'b1;
      if (ovf_ev && ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_echo_bridge.sv
// tb/tb_uart_echo_bridge.sv - directed self-checking bench for uart_echo_bridge
module tb_uart_echo_bridge;
  import uart_pkg::*;

  localparam int CPB  = 16;
  localparam int LAST = 10;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       parity_mode = PARITY_EVEN;
  logic       uart_rx = 1'b1;
  logic       clr_status = 1'b0;
  logic       uart_tx;
  logic [4:0] rx_level;
  logic       overflow;
  logic       frame_err;
`ifdef UART_BRIDGE_STATS_EN
  logic [15:0] err_cnt;
  logic [15:0] ovf_cnt;
`endif

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rx_done_cyc = -1;
  int tx_start_cyc = -1;
  int peak = 0;

  always #5 clk = ~clk;

  uart_echo_bridge #(
    .CLK_FREQ   (16),
    .BAUD_RATE  (1),
    .DATA_BITS  (8),
    .STOP_BITS  (1),
    .FIFO_DEPTH (16)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .parity_mode (parity_mode),
    .uart_rx     (uart_rx),
    .uart_tx     (uart_tx),
    .clr_status  (clr_status),
    .rx_level    (rx_level),
    .overflow    (overflow),
    .frame_err   (frame_err)
`ifdef UART_BRIDGE_STATS_EN
    ,
    .err_cnt     (err_cnt),
    .ovf_cnt     (ovf_cnt)
`endif
  );

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (dut.rx_done)  rx_done_cyc = cyc;
    if (dut.tx_start) tx_start_cyc = cyc;
    if (int'(rx_level) > peak) peak = int'(rx_level);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    uart_rx = 1'b1;
    clr_status = 1'b0;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad_parity);
    logic [10:0] fr;
    fr = {1'b1, (^d) ^ parity_mode ^ bad_parity, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      uart_rx = fr[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic recv_frame(output logic [7:0] d, output logic ok, input int budget);
    int n;
    logic par;
    n = 0;
    ok = 1'b0;
    d = 8'h00;
    while (uart_tx !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (uart_tx === 1'b0) begin
      repeat (CPB / 2) @(negedge clk);
      if (uart_tx === 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          d[i] = uart_tx;
        end
        repeat (CPB) @(negedge clk);
        par = uart_tx;
        repeat (CPB) @(negedge clk);
        ok = (uart_tx === 1'b1) && (par === ((^d) ^ parity_mode));
      end
    end
  endtask

  // Returns at the negedge just before the edge that raises rx_done.
  task automatic wait_rx_predone(output logic hit);
    int n;
    n = 0;
    hit = 1'b0;
    while (!hit && n < 400) begin
      @(negedge clk);
      n++;
      hit = dut.u_rx.active && int'(dut.u_rx.idx) == LAST && int'(dut.u_rx.cnt) == CPB - 1;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests++; if (uart_tx !== 1'b1) begin fails++; $display("FAIL reset_uart_tx: got %b expected 1", uart_tx); end
    tests++; if (rx_level !== 5'd0) begin fails++; $display("FAIL reset_rx_level: got %0d expected 0", rx_level); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    tests++; if (dut.tx_start !== 1'b0) begin fails++; $display("FAIL reset_tx_start: got %b expected 0", dut.tx_start); end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_echo();
    logic [7:0] d;
    logic ok;
    rx_done_cyc = -1;
    tx_start_cyc = -1;
    fork
      send_frame(8'h55, 1'b0);
      recv_frame(d, ok, 600);
    join
    tests++; if (ok !== 1'b1 || d !== 8'h55) begin fails++; $display("FAIL single_echo: got ok=%b data=%h expected ok=1 data=55", ok, d); end
    tests++; if (tx_start_cyc - rx_done_cyc != 2) begin fails++; $display("FAIL single_latency: got %0d expected 2", tx_start_cyc - rx_done_cyc); end
    tests++; if (rx_level !== 5'd0) begin fails++; $display("FAIL single_level: got %0d expected 0", rx_level); end
    tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL single_frame_err: got %b expected 0", frame_err); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    logic ok;
    do_reset();
    peak = 0;
    force dut.fifo_empty = 1'b1;
    for (int i = 0; i < 20; i++) send_frame(8'(i), 1'b0);
    tests++; if (peak != 16) begin fails++; $display("FAIL b2b_peak: got %0d expected 16", peak); end
    tests++; if (rx_level !== 5'd16) begin fails++; $display("FAIL b2b_level_full: got %0d expected 16", rx_level); end
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL b2b_overflow: got %b expected 1", overflow); end
    release dut.fifo_empty;
    for (int i = 0; i < 16; i++) begin
      recv_frame(d, ok, 100);
      tests++; if (ok !== 1'b1 || d !== 8'(i)) begin fails++; $display("FAIL b2b_echo[%0d]: got ok=%b data=%h expected ok=1 data=%h", i, ok, d, 8'(i)); end
    end
    recv_frame(d, ok, 400);
    tests++; if (ok !== 1'b0) begin fails++; $display("FAIL b2b_extra_frame: got data=%h expected no frame", d); end
    tests++; if (rx_level !== 5'd0) begin fails++; $display("FAIL b2b_level_drained: got %0d expected 0", rx_level); end
  endtask

  task automatic test_parity_error();
    logic [7:0] d;
    logic ok;
    logic hit;
    do_reset();
    fork
      send_frame(8'hA5, 1'b1);
      recv_frame(d, ok, 400);
    join
    tests++; if (ok !== 1'b0) begin fails++; $display("FAIL perr_no_echo: got data=%h expected no frame", d); end
    tests++; if (frame_err !== 1'b1) begin fails++; $display("FAIL perr_frame_err: got %b expected 1", frame_err); end
    tests++; if (rx_level !== 5'd0) begin fails++; $display("FAIL perr_level: got %0d expected 0", rx_level); end
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
    @(negedge clk);
    tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL perr_clear: got %b expected 0", frame_err); end
    fork
      send_frame(8'hA5, 1'b1);
      begin
        wait_rx_predone(hit);
        tests++; if (hit !== 1'b1) begin fails++; $display("FAIL perr_sync: got %b expected 1", hit); end
        @(negedge clk);
        clr_status = 1'b1;
        @(negedge clk);
        clr_status = 1'b0;
        tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL perr_clr_wins: got %b expected 0", frame_err); end
        @(negedge clk);
        tests++; if (frame_err !== 1'b1) begin fails++; $display("FAIL perr_reset_next: got %b expected 1", frame_err); end
      end
    join
  endtask

  task automatic test_reset_mid_echo();
    logic [7:0] d;
    logic ok;
    do_reset();
    send_frame(8'h3C, 1'b0);
    repeat (2) @(negedge clk);
    tests++; if (uart_tx !== 1'b0) begin fails++; $display("FAIL midrst_start_bit: got %b expected 0", uart_tx); end
    rstn = 1'b0;
    #1;
    tests++; if (uart_tx !== 1'b1) begin fails++; $display("FAIL midrst_uart_tx: got %b expected 1", uart_tx); end
    tests++; if (rx_level !== 5'd0) begin fails++; $display("FAIL midrst_level: got %0d expected 0", rx_level); end
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    recv_frame(d, ok, 400);
    tests++; if (ok !== 1'b0 || uart_tx !== 1'b1) begin fails++; $display("FAIL midrst_no_output: got ok=%b data=%h expected no frame", ok, d); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] d;
    logic ok;
    logic hit;
    do_reset();
    force dut.fifo_empty = 1'b1;
    for (int i = 0; i < 16; i++) send_frame(8'h20 + 8'(i), 1'b0);
    tests++; if (rx_level !== 5'd16) begin fails++; $display("FAIL fullpp_level_pre: got %0d expected 16", rx_level); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL fullpp_overflow_pre: got %b expected 0", overflow); end
    fork
      send_frame(8'h30, 1'b0);
      begin
        wait_rx_predone(hit);
        release dut.fifo_empty;
        @(negedge clk);
        tests++; if (hit !== 1'b1 || dut.rx_done !== 1'b1 || dut.tx_start !== 1'b1) begin fails++; $display("FAIL fullpp_coincide: got hit=%b rx_done=%b tx_start=%b expected 1 1 1", hit, dut.rx_done, dut.tx_start); end
        @(negedge clk);
        tests++; if (rx_level !== 5'd16) begin fails++; $display("FAIL fullpp_level: got %0d expected 16", rx_level); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL fullpp_overflow: got %b expected 0", overflow); end
        for (int i = 0; i < 17; i++) begin
          recv_frame(d, ok, 100);
          tests++; if (ok !== 1'b1 || d !== 8'h20 + 8'(i)) begin fails++; $display("FAIL fullpp_echo[%0d]: got ok=%b data=%h expected ok=1 data=%h", i, ok, d, 8'h20 + 8'(i)); end
        end
      end
    join
  endtask

`ifdef UART_BRIDGE_STATS_EN
  task automatic test_stats();
    do_reset();
    for (int i = 0; i < 3; i++) send_frame(8'h11 * 8'(i + 1), 1'b1);
    repeat (4) @(negedge clk);
    tests++; if (err_cnt !== 16'd3) begin fails++; $display("FAIL stats_err_cnt: got %0d expected 3", err_cnt); end
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
    @(negedge clk);
    tests++; if (err_cnt !== 16'd3) begin fails++; $display("FAIL stats_err_cnt_after_clr: got %0d expected 3", err_cnt); end
    tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL stats_frame_err_clr: got %b expected 0", frame_err); end
    tests++; if (ovf_cnt !== 16'd0) begin fails++; $display("FAIL stats_ovf_cnt: got %0d expected 0", ovf_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_echo();
    test_back_to_back();
    test_parity_error();
    test_reset_mid_echo();
    test_full_push_pop();
`ifdef UART_BRIDGE_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
